// File: rtl/row_readout_arbiter.sv
// Round-robin arbiter sharing one SPI readout engine among the detector rows.
// Synchronizes each row's active-low interrupt, grants one pending row at a
// time, holds it through setup/readout/release and guards readout with a timeout.
module row_readout_arbiter #(
   parameter int unsigned NUM_ROWS          = 20,
   parameter int unsigned HOLD_SETUP_CYCLES = 4,
   parameter int unsigned RELEASE_CYCLES    = 3,
   parameter int unsigned TIMEOUT_CYCLES    = 65535,
   localparam int unsigned IW               = $clog2(NUM_ROWS)
) (
   input  logic                clk_core,
   input  logic                resn,
   input  logic                enable,
   input  logic [NUM_ROWS-1:0] row_mask,
   input  logic [NUM_ROWS-1:0] row_interruptn,
   output logic [NUM_ROWS-1:0] row_hold,
   output logic                rd_req,
   output logic [IW-1:0]       rd_row,
   input  logic                rd_done,
   output logic                rd_abort,
   output logic                busy,
   output logic [7:0]          timeout_count
);

   typedef enum logic [1:0] {StIdle, StHoldSetup, StReadout, StRelease} state_t;

   localparam logic [IW:0] NumRowsW = (IW + 1)'(NUM_ROWS);

   state_t              state;
   logic [NUM_ROWS-1:0] sync1;
   logic [NUM_ROWS-1:0] sync2;
   logic [NUM_ROWS-1:0] pending;
   logic [NUM_ROWS-1:0] grant_vec;
   logic [IW-1:0]       ptr;
   logic [IW-1:0]       next_ptr;
   logic [IW-1:0]       sel;
   logic [IW:0]         cand;
   logic                found;
   logic [15:0]         cnt;

   // Two-flop synchronizer; reset to 1 so no row looks pending out of reset.
   always_ff @(posedge clk_core or negedge resn) begin
      if (!resn) begin
         sync1 <= '1;
         sync2 <= '1;
      end else begin
         sync1 <= row_interruptn;
         sync2 <= sync1;
      end
   end

   assign pending = ~sync2 & ~row_mask;

   // First pending row at or after ptr, wrapping past the last row.
   always_comb begin
      found = 1'b0;
      sel   = '0;
      cand  = '0;
      for (int i = 0; i < NUM_ROWS; i++) begin
         cand = {1'b0, ptr} + (IW + 1)'(i);
         if (cand >= NumRowsW) cand = cand - NumRowsW;
         if (!found && pending[cand[IW-1:0]]) begin
            found = 1'b1;
            sel   = cand[IW-1:0];
         end
      end
   end

   // One-hot hold vector for the selected row and the post-release pointer.
   always_comb begin
      grant_vec      = '0;
      grant_vec[sel] = 1'b1;
      next_ptr       = (rd_row == IW'(NUM_ROWS - 1)) ? '0 : rd_row + IW'(1);
   end

   // Transaction FSM with registered outputs; cnt is shared by all timed states.
   always_ff @(posedge clk_core or negedge resn) begin
      if (!resn) begin
         state         <= StIdle;
         ptr           <= '0;
         cnt           <= '0;
         row_hold      <= '0;
         rd_req        <= 1'b0;
         rd_row        <= '0;
         rd_abort      <= 1'b0;
         timeout_count <= '0;
      end else begin
         rd_abort <= 1'b0;
         case (state)
            StIdle: begin
               if (enable && found) begin
                  rd_row   <= sel;
                  row_hold <= grant_vec;
                  cnt      <= '0;
                  state    <= StHoldSetup;
               end
            end
            StHoldSetup: begin
               if (cnt == 16'(HOLD_SETUP_CYCLES - 1)) begin
                  rd_req <= 1'b1;
                  cnt    <= '0;
                  state  <= StReadout;
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end
            StReadout: begin
               // rd_done takes priority over a timeout expiring in the same cycle.
               if (rd_done) begin
                  rd_req   <= 1'b0;
                  row_hold <= '0;
                  ptr      <= next_ptr;
                  cnt      <= '0;
                  state    <= StRelease;
               end else if (cnt == 16'(TIMEOUT_CYCLES - 1)) begin
                  rd_abort <= 1'b1;
                  rd_req   <= 1'b0;
                  row_hold <= '0;
                  ptr      <= next_ptr;
                  cnt      <= '0;
                  if (timeout_count != 8'hFF) timeout_count <= timeout_count + 8'd1;
                  state    <= StRelease;
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end
            StRelease: begin
               // Gives a just-cleared interrupt time to resynchronize.
               if (cnt == 16'(RELEASE_CYCLES - 1)) begin
                  cnt   <= '0;
                  state <= StIdle;
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end
            default: state <= StIdle;
         endcase
      end
   end

   assign busy = (state != StIdle);

endmodule

// File: tb/tb_row_readout_arbiter.sv
// Directed bench for row_readout_arbiter with a short timeout.
module tb_row_readout_arbiter;

   localparam int unsigned NR = 20;

   logic          clk_core = 1'b0;
   logic          resn = 1'b0;
   logic          enable = 1'b1;
   logic [NR-1:0] row_mask = '0;
   logic [NR-1:0] row_interruptn = '1;
   logic [NR-1:0] row_hold;
   logic          rd_req;
   logic [4:0]    rd_row;
   logic          rd_done = 1'b0;
   logic          rd_abort;
   logic          busy;
   logic [7:0]    timeout_count;

   int checks = 0;
   int passed = 0;
   int fails  = 0;

   row_readout_arbiter #(
      .NUM_ROWS(NR),
      .HOLD_SETUP_CYCLES(4),
      .RELEASE_CYCLES(3),
      .TIMEOUT_CYCLES(16)
   ) dut (
      .clk_core(clk_core),
      .resn(resn),
      .enable(enable),
      .row_mask(row_mask),
      .row_interruptn(row_interruptn),
      .row_hold(row_hold),
      .rd_req(rd_req),
      .rd_row(rd_row),
      .rd_done(rd_done),
      .rd_abort(rd_abort),
      .busy(busy),
      .timeout_count(timeout_count)
   );

   always #5 clk_core = ~clk_core;

   task automatic tick(input int n);
      repeat (n) @(posedge clk_core);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) begin
         passed++;
      end else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      resn = 1'b0;
      tick(2);
      resn = 1'b1;
      tick(1);
   endtask

   task automatic wait_req(input string tag, input int budget);
      int n = 0;
      while (!rd_req && n < budget) begin
         tick(1);
         n++;
      end
      chk(tag, 32'(rd_req), 32'd1);
   endtask

   task automatic pulse_done();
      rd_done = 1'b1;
      tick(1);
      rd_done = 1'b0;
   endtask

   initial begin
      int order [5];
      int n;
      int aborts;
      order = '{2, 5, 19, 2, 5};

      // Reset state
      do_reset();
      chk("rst_hold", 32'(row_hold), 32'd0);
      chk("rst_req", 32'(rd_req), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_tc", 32'(timeout_count), 32'd0);

      // Single row 7: hold 3 clocks after the pin, req 4 clocks after hold
      row_interruptn[7] = 1'b0;
      tick(2);
      chk("single_hold_early", 32'(row_hold), 32'd0);
      tick(1);
      chk("single_hold", 32'(row_hold), 32'h00080);
      chk("single_busy", 32'(busy), 32'd1);
      tick(3);
      chk("single_req_early", 32'(rd_req), 32'd0);
      tick(1);
      chk("single_req", 32'(rd_req), 32'd1);
      chk("single_row", 32'(rd_row), 32'd7);
      row_interruptn[7] = 1'b1;
      pulse_done();
      chk("single_req_off", 32'(rd_req), 32'd0);
      chk("single_hold_off", 32'(row_hold), 32'd0);
      tick(2);
      chk("single_busy_rel", 32'(busy), 32'd1);
      tick(1);
      chk("single_busy_off", 32'(busy), 32'd0);
      tick(6);
      chk("single_no_regrant", 32'(busy), 32'd0);

      // Round-robin over rows 2, 5, 19 with wrap back to 2
      do_reset();
      row_interruptn[2]  = 1'b0;
      row_interruptn[5]  = 1'b0;
      row_interruptn[19] = 1'b0;
      for (int i = 0; i < 5; i++) begin
         wait_req("rr_req", 30);
         chk("rr_row", 32'(rd_row), 32'(order[i]));
         chk("rr_hold", 32'(row_hold), 32'd1 << order[i]);
         if (i == 4) row_interruptn = '1;
         pulse_done();
      end
      tick(12);
      chk("rr_idle", 32'(busy), 32'd0);

      // Timeout: req high exactly 16 clocks, then one abort pulse
      do_reset();
      row_interruptn[3] = 1'b0;
      wait_req("to_req", 30);
      n = 0;
      while (rd_req && n < 100) begin
         tick(1);
         n++;
      end
      chk("to_req_len", 32'(n), 32'd16);
      chk("to_abort", 32'(rd_abort), 32'd1);
      chk("to_hold_off", 32'(row_hold), 32'd0);
      chk("to_tc1", 32'(timeout_count), 32'd1);
      tick(1);
      chk("to_abort_pulse", 32'(rd_abort), 32'd0);
      aborts = 1;
      n = 0;
      while (aborts < 300 && n < 9000) begin
         tick(1);
         n++;
         if (rd_abort) aborts++;
      end
      chk("to_aborts", 32'(aborts), 32'd300);
      chk("to_tc_sat", 32'(timeout_count), 32'd255);
      row_interruptn[3] = 1'b1;
      tick(10);
      chk("to_idle", 32'(busy), 32'd0);

      // Masked row is never granted
      do_reset();
      row_mask[4] = 1'b1;
      row_interruptn[4] = 1'b0;
      tick(10);
      chk("mask_busy", 32'(busy), 32'd0);
      chk("mask_hold", 32'(row_hold), 32'd0);
      row_interruptn[4] = 1'b1;
      row_mask[4] = 1'b0;

      // enable low blocks grants; dropping it mid-readout lets the transfer finish
      enable = 1'b0;
      row_interruptn[1] = 1'b0;
      tick(10);
      chk("en_busy", 32'(busy), 32'd0);
      enable = 1'b1;
      wait_req("en_req", 30);
      chk("en_row", 32'(rd_row), 32'd1);
      enable = 1'b0;
      row_interruptn[1] = 1'b1;
      row_interruptn[6] = 1'b0;
      tick(3);
      chk("en_req_hold", 32'(rd_req), 32'd1);
      pulse_done();
      chk("en_req_off", 32'(rd_req), 32'd0);
      tick(12);
      chk("en_no_grant", 32'(busy), 32'd0);
      chk("en_no_hold", 32'(row_hold), 32'd0);
      row_interruptn[6] = 1'b1;
      enable = 1'b1;

      // rd_done in the same cycle the timeout would expire
      do_reset();
      row_interruptn[3] = 1'b0;
      wait_req("sim_req", 30);
      chk("sim_row", 32'(rd_row), 32'd3);
      row_interruptn[3] = 1'b1;
      tick(15);
      chk("sim_req_still", 32'(rd_req), 32'd1);
      pulse_done();
      chk("sim_no_abort", 32'(rd_abort), 32'd0);
      chk("sim_req_off", 32'(rd_req), 32'd0);
      chk("sim_tc", 32'(timeout_count), 32'd0);
      tick(3);
      chk("sim_idle", 32'(busy), 32'd0);

      // Move ptr to 13, then reset during readout of row 14
      row_interruptn[12] = 1'b0;
      wait_req("mr_req12", 30);
      chk("mr_row12", 32'(rd_row), 32'd12);
      row_interruptn[12] = 1'b1;
      pulse_done();
      tick(4);
      row_interruptn[10] = 1'b0;
      row_interruptn[14] = 1'b0;
      wait_req("mr_req14", 30);
      chk("mr_row14", 32'(rd_row), 32'd14);
      tick(2);
      resn = 1'b0;
      #1;
      chk("mr_hold0", 32'(row_hold), 32'd0);
      chk("mr_req0", 32'(rd_req), 32'd0);
      chk("mr_row0", 32'(rd_row), 32'd0);
      chk("mr_busy0", 32'(busy), 32'd0);
      chk("mr_abort0", 32'(rd_abort), 32'd0);
      tick(1);
      resn = 1'b1;
      wait_req("mr_req_after", 30);
      chk("mr_row_after", 32'(rd_row), 32'd10);
      chk("mr_hold_after", 32'(row_hold), 32'd1 << 10);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/row_readout_arbiter.md
# row_readout_arbiter

Round-robin scheduler that shares the single core-side SPI readout engine among the 20 detector rows. It watches each row's active-low interrupt, selects one pending row, asserts that row's hold, and starts the engine for it. It then waits for completion or a timeout before releasing the row and moving to the next. It sits inside `astep24_20l_top` between the `layer_N_interruptn`/`layer_N_hold` pins and the readout engine, all in the `clk_core` domain.

## Interface
- `NUM_ROWS`, 20: number of rows arbitrated; the index width is `IW = $clog2(NUM_ROWS)` (5).
- `HOLD_SETUP_CYCLES`, 4: clocks from hold assertion to the readout request; legal range 1..255.
- `RELEASE_CYCLES`, 3: clocks from hold release to re-arbitration; minimum 3, which covers the synchronizer plus 1.
- `TIMEOUT_CYCLES`, 65535: maximum clocks `rd_req` may stay high without `rd_done`; legal range 1..65535.

Ports:
- `clk_core`, in, 1: core clock. One clock only.
- `resn`, in, 1: reset, asynchronous, active-low.
- `enable`, in, 1: allows new grants.
- `row_mask`, in, NUM_ROWS: 1 excludes the row from arbitration.
- `row_interruptn`, in, NUM_ROWS: raw pin level, asynchronous; low means data pending.
- `row_hold`, out, NUM_ROWS: one-hot hold to the granted row, registered.
- `rd_req`, out, 1: readout request to the engine, held until done or abort.
- `rd_row`, out, IW: granted row index, stable while `rd_req` is high.
- `rd_done`, in, 1: single-cycle pulse from the engine when the readout completes.
- `rd_abort`, out, 1: single-cycle pulse on timeout; the engine must return to idle.
- `busy`, out, 1: high in any state other than IDLE.
- `timeout_count`, out, 8: saturating count of timeouts since reset.

## Operation
- Each `row_interruptn` bit passes through a 2-flop synchronizer.
- A row is pending when its synchronized interrupt is low and its `row_mask` bit is 0.
- The state machine has four states: IDLE, HOLD_SETUP, READOUT, RELEASE.
- **IDLE:** when `enable` is 1 and any row is pending, select the first pending row at or after `ptr`, in increasing index order with wrap from NUM_ROWS-1 to 0.
  - Latch the selection into `rd_row`.
  - Set `row_hold[rd_row]`.
  - Go to HOLD_SETUP.
- **HOLD_SETUP:** count HOLD_SETUP_CYCLES clocks, then set `rd_req`, clear the timeout counter, and go to READOUT.
- **READOUT:** `rd_req` stays high.
  - On `rd_done`: clear `rd_req` and go to RELEASE.
  - If the timeout counter reaches TIMEOUT_CYCLES without `rd_done`: pulse `rd_abort`, clear `rd_req`, increment `timeout_count` (saturating at 255), and go to RELEASE.
  - If `rd_done` and the timeout fall in the same cycle, `rd_done` wins: no abort and no count.
- **RELEASE:**
  - On entry: clear all of `row_hold` and set `ptr` to `rd_row+1`, wrapping to 0 after NUM_ROWS-1.
  - Wait RELEASE_CYCLES clocks, then return to IDLE. This lets a stale interrupt resynchronize before arbitration.
- **`enable` low:** blocks only the IDLE→HOLD_SETUP transition. A transaction already in progress completes normally.
- **Masking the granted row mid-transaction:** has no effect on that transaction.
- **`rd_done` outside READOUT:** ignored.
- **Reset (asserted at any time, including mid-transaction):**
  - State = IDLE, `ptr` = 0, counters = 0, synchronizers = 1 (not pending).
  - Outputs: `row_hold` = 0, `rd_req` = 0, `rd_row` = 0, `rd_abort` = 0, `busy` = 0, `timeout_count` = 0.
- At most one `row_hold` bit is ever high.

## Timing
- Interrupt pin to pending: 2 clocks.
- Pending seen in IDLE to `row_hold` high: 1 clock.
- `row_hold` high to `rd_req` high: exactly HOLD_SETUP_CYCLES clocks.
- `rd_req` high to `rd_row` stable: `rd_row` is valid from the cycle `row_hold` rises until RELEASE exits.
- `rd_done` sampled high: `rd_req` and `row_hold` are low on the next clock.
- Timeout: `rd_abort` is high in the clock that `rd_req` falls, for TIMEOUT_CYCLES clocks of `rd_req` high in total.
- Minimum transaction (`rd_done` on the first READOUT cycle): 1 + HOLD_SETUP_CYCLES + 1 + RELEASE_CYCLES clocks from grant to the next IDLE.
- `busy` rises with `row_hold` and falls on the clock IDLE is re-entered.

## Test plan
- **Single row:** reset, then drive row 7 interruptn low with `enable`=1.
  - `row_hold`=20'h00080 three clocks after the pin falls.
  - `rd_req`=1 with `rd_row`=7 four clocks later.
  - Pulse `rd_done`: hold and req are low next clock; `busy` falls after 3 more clocks.
- **Round-robin:** rows 2, 5 and 19 held pending, `rd_done` returned immediately each time.
  - Grant order 2, 5, 19, 2, 5.
  - After 19 the pointer wraps to 0.
- **Timeout:** TIMEOUT_CYCLES=16, row 3 pending, `rd_done` never sent.
  - `rd_req` is high for exactly 16 clocks, then a single `rd_abort` pulse.
  - `timeout_count`=1 and hold is released.
  - After 300 repeats, `timeout_count`=255 (saturated).
- **Mask and enable:**
  - With `row_mask[4]`=1 and row 4 pending: no grant.
  - With `enable`=0 and row 1 pending: no grant.
  - Drop `enable` during READOUT: the transaction completes on `rd_done`, then no new grant is issued.
- **Simultaneous done and timeout:** `rd_done` arrives in the cycle the timeout expires.
  - No `rd_abort`, `timeout_count` unchanged, normal RELEASE.
- **Reset mid-transaction:** assert `resn`=0 during READOUT.
  - All outputs are 0 immediately (asynchronous).
  - After release, with row 10 still pending, the first grant is row 10, because arbitration starts from `ptr`=0 and no lower-index row is pending.
